// File: rtl/flght_cntrl_pid.sv
// flght_cntrl_pid: three-axis PID flight controller with a single shared
// P/I/D datapath, time-multiplexed over pitch, roll and yaw by a small FSM.
// The three axis results are mixed with thrust into four saturated motor
// speeds, which are registered and announced with a one-cycle strobe.
module flght_cntrl_pid #(
  parameter int SPD_W         = 11,
  parameter int THRST_W       = 9,
  parameter int ERR_W         = 10,
  parameter int D_DEPTH       = 12,
  parameter int D_COEFF       = 7,
  parameter int I_SHIFT       = 6,
  parameter int I_LIM         = 4095,
  parameter int CAL_SPEED     = 'h290,
  parameter int MIN_RUN_SPEED = 'h2C0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld,
  input  logic                inertial_cal,
  input  logic signed [15:0]  d_ptch,
  input  logic signed [15:0]  d_roll,
  input  logic signed [15:0]  d_yaw,
  input  logic signed [15:0]  ptch,
  input  logic signed [15:0]  roll,
  input  logic signed [15:0]  yaw,
  input  logic [THRST_W-1:0]  thrst,
  output logic [SPD_W-1:0]    frnt_spd,
  output logic [SPD_W-1:0]    bck_spd,
  output logic [SPD_W-1:0]    lft_spd,
  output logic [SPD_W-1:0]    rght_spd,
  output logic                spd_vld,
  output logic                overrun
);

  // Axis sums and mix terms are carried at SPD_W+2 signed bits.
  localparam int MIX_W   = SPD_W + 2;
  // Integrator holds +/-I_LIM plus a sign bit.
  localparam int INT_W   = $clog2(I_LIM + 1) + 1;
  localparam int PTR_W   = $clog2(D_DEPTH);
  localparam int ERR_MAX = (1 << (ERR_W - 1)) - 1;
  localparam int ERR_MIN = -(1 << (ERR_W - 1));
  localparam int DIF_MAX = 63;
  localparam int DIF_MIN = -64;
  localparam int SPD_MAX = (1 << SPD_W) - 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] AX_PTCH = 3'd1;
  localparam logic [2:0] AX_ROLL = 3'd2;
  localparam logic [2:0] AX_YAW  = 3'd3;
  localparam logic [2:0] MIX     = 3'd4;
  localparam logic [2:0] UPD     = 3'd5;

  logic [2:0]               state_reg;
  logic [2:0]               state_next;

  // Captured sample; element 0 = pitch, 1 = roll, 2 = yaw.
  logic [2:0][15:0]         act_reg;
  logic [2:0][15:0]         des_reg;
  logic [THRST_W-1:0]       thrst_reg;

  // Shared write pointer into the three circular D-queues. The slot it
  // points at holds the oldest entry, which is read and then overwritten.
  logic [PTR_W-1:0]         dq_ptr_reg;

  logic [2:0][ERR_W-1:0]    dq_old;
  logic [2:0][INT_W-1:0]    integ_all;
  logic [2:0][MIX_W-1:0]    s_all;

  logic [1:0]               ax_idx;
  logic                     ax_active;
  logic signed [15:0]       act_sel;
  logic signed [15:0]       des_sel;

  logic signed [ERR_W-1:0]  err_q;
  logic signed [INT_W-1:0]  integ_q;
  logic signed [MIX_W-1:0]  s_q;

  logic [3:0][SPD_W-1:0]    mix_next;
  logic [3:0][SPD_W-1:0]    mix_reg;

  // Clamp a mix result into the unsigned motor speed range.
  function automatic logic [SPD_W-1:0] sat_spd(input int v);
    if (v < 0) begin
      return '0;
    end else if (v > SPD_MAX) begin
      return SPD_W'(SPD_MAX);
    end
    return SPD_W'(v);
  endfunction

  // Sequence: accept in IDLE, one cycle per axis, then mix and update.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = vld ? AX_PTCH : IDLE;
      AX_PTCH: state_next = AX_ROLL;
      AX_ROLL: state_next = AX_YAW;
      AX_YAW:  state_next = MIX;
      MIX:     state_next = UPD;
      UPD:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the inertial sample and thrust only when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_reg   <= '0;
      des_reg   <= '0;
      thrst_reg <= '0;
    end else if (state_reg == IDLE && vld) begin
      act_reg   <= {yaw, roll, ptch};
      des_reg   <= {d_yaw, d_roll, d_ptch};
      thrst_reg <= thrst;
    end
  end

  // Sticky flag: a reading arrived while a sequence was in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (vld && state_reg != IDLE) begin
      overrun <= 1'b1;
    end
  end

  // Decode which axis the shared datapath is serving this cycle.
  always_comb begin
    ax_idx    = 2'd0;
    ax_active = 1'b0;
    case (state_reg)
      AX_PTCH: begin ax_idx = 2'd0; ax_active = 1'b1; end
      AX_ROLL: begin ax_idx = 2'd1; ax_active = 1'b1; end
      AX_YAW:  begin ax_idx = 2'd2; ax_active = 1'b1; end
      default: begin ax_idx = 2'd0; ax_active = 1'b0; end
    endcase
  end

  assign act_sel = act_reg[ax_idx];
  assign des_sel = des_reg[ax_idx];

  // Shared P/I/D datapath for the selected axis. Arithmetic is done in
  // 32-bit ints so no intermediate can wrap before saturation.
  always_comb begin
    int err_i;
    int diff_i;
    int integ_i;
    int s_i;
    err_i = int'(act_sel) - int'(des_sel);
    if (err_i > ERR_MAX) begin
      err_i = ERR_MAX;
    end else if (err_i < ERR_MIN) begin
      err_i = ERR_MIN;
    end

    diff_i = err_i - int'($signed(dq_old[ax_idx]));
    if (diff_i > DIF_MAX) begin
      diff_i = DIF_MAX;
    end else if (diff_i < DIF_MIN) begin
      diff_i = DIF_MIN;
    end

    if (inertial_cal) begin
      integ_i = 0;
    end else begin
      integ_i = int'($signed(integ_all[ax_idx])) + err_i;
      if (integ_i > I_LIM) begin
        integ_i = I_LIM;
      end else if (integ_i < -I_LIM) begin
        integ_i = -I_LIM;
      end
    end

    // I term uses the freshly updated integrator value.
    s_i = (err_i >>> 1) + (err_i >>> 3) + (diff_i * D_COEFF) + (integ_i >>> I_SHIFT);

    err_q   = ERR_W'(err_i);
    integ_q = INT_W'(integ_i);
    s_q     = MIX_W'(s_i);
  end

  // Per-axis state: D-queue, integrator and result register.
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic signed [ERR_W-1:0] q_reg [D_DEPTH];
    logic signed [INT_W-1:0] integ_reg;
    logic signed [MIX_W-1:0] s_reg;
    logic                    hit;

    assign hit = ax_active && (ax_idx == 2'(gi));

    // Push the new error over the oldest entry and latch this axis's result.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < D_DEPTH; i++) begin
          q_reg[i] <= '0;
        end
        integ_reg <= '0;
        s_reg     <= '0;
      end else if (hit) begin
        q_reg[dq_ptr_reg] <= err_q;
        integ_reg         <= integ_q;
        s_reg             <= s_q;
      end
    end

    assign dq_old[gi]    = q_reg[dq_ptr_reg];
    assign integ_all[gi] = integ_reg;
    assign s_all[gi]     = s_reg;
  end

  // Advance the queue pointer once all three axes have pushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dq_ptr_reg <= '0;
    end else if (state_reg == AX_YAW) begin
      dq_ptr_reg <= (dq_ptr_reg == PTR_W'(D_DEPTH - 1)) ? '0 : dq_ptr_reg + 1'b1;
    end
  end

  // Motor mix; order is front, back, left, right. Values stay well inside
  // SPD_W+2 signed bits for the supported parameter range.
  always_comb begin
    int base_i;
    int sp_i;
    int sr_i;
    int sy_i;
    base_i = int'(thrst_reg) + MIN_RUN_SPEED;
    sp_i   = int'($signed(s_all[0]));
    sr_i   = int'($signed(s_all[1]));
    sy_i   = int'($signed(s_all[2]));
    mix_next[0] = sat_spd(base_i - sp_i - sy_i);
    mix_next[1] = sat_spd(base_i + sp_i - sy_i);
    mix_next[2] = sat_spd(base_i - sr_i + sy_i);
    mix_next[3] = sat_spd(base_i + sr_i + sy_i);
  end

  // Register the saturated mix during MIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mix_reg <= '0;
    end else if (state_reg == MIX) begin
      mix_reg <= mix_next;
    end
  end

  // Load the speed outputs in UPD and pulse the strobe for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frnt_spd <= '0;
      bck_spd  <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
    end else begin
      spd_vld <= (state_reg == UPD);
      if (state_reg == UPD) begin
        if (inertial_cal) begin
          frnt_spd <= SPD_W'(CAL_SPEED);
          bck_spd  <= SPD_W'(CAL_SPEED);
          lft_spd  <= SPD_W'(CAL_SPEED);
          rght_spd <= SPD_W'(CAL_SPEED);
        end else begin
          frnt_spd <= mix_reg[0];
          bck_spd  <= mix_reg[1];
          lft_spd  <= mix_reg[2];
          rght_spd <= mix_reg[3];
        end
      end
    end
  end

endmodule

// File: tb/tb_flght_cntrl_pid.sv
// Self-checking bench for flght_cntrl_pid: directed scenarios plus randomized
// transactions compared against a behavioural model of the control law.
module tb_flght_cntrl_pid;

  localparam int SPD_W   = 11;
  localparam int THRST_W = 9;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld = 1'b0;
  logic               inertial_cal = 1'b0;
  logic signed [15:0] d_ptch = '0;
  logic signed [15:0] d_roll = '0;
  logic signed [15:0] d_yaw = '0;
  logic signed [15:0] ptch = '0;
  logic signed [15:0] roll = '0;
  logic signed [15:0] yaw = '0;
  logic [THRST_W-1:0] thrst = '0;
  logic [SPD_W-1:0]   frnt_spd;
  logic [SPD_W-1:0]   bck_spd;
  logic [SPD_W-1:0]   lft_spd;
  logic [SPD_W-1:0]   rght_spd;
  logic               spd_vld;
  logic               overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn = 0;

  // Model state: last 12 errors per axis (index 0 oldest), integrators,
  // expected speeds (front, back, left, right) and expected overrun.
  int m_hist[3][12];
  int m_integ[3];
  int exp_spd[4];
  int exp_ovr;

  always #5 clk = ~clk;

  flght_cntrl_pid dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .inertial_cal (inertial_cal),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .ptch         (ptch),
    .roll         (roll),
    .yaw          (yaw),
    .thrst        (thrst),
    .frnt_spd     (frnt_spd),
    .bck_spd      (bck_spd),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .spd_vld      (spd_vld),
    .overrun      (overrun)
  );

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    for (int ax = 0; ax < 3; ax++) begin
      m_integ[ax] = 0;
      for (int i = 0; i < 12; i++) m_hist[ax][i] = 0;
    end
    for (int k = 0; k < 4; k++) exp_spd[k] = 0;
    exp_ovr = 0;
  endtask

  // Apply the control law to the currently driven inputs.
  task automatic model_accept();
    int act[3];
    int des[3];
    int s[3];
    int err;
    int diff;
    int base;
    act[0] = int'(ptch);   act[1] = int'(roll);   act[2] = int'(yaw);
    des[0] = int'(d_ptch); des[1] = int'(d_roll); des[2] = int'(d_yaw);
    for (int ax = 0; ax < 3; ax++) begin
      err  = clampi(act[ax] - des[ax], -512, 511);
      diff = clampi(err - m_hist[ax][0], -64, 63);
      for (int i = 0; i < 11; i++) m_hist[ax][i] = m_hist[ax][i+1];
      m_hist[ax][11] = err;
      m_integ[ax] = inertial_cal ? 0 : clampi(m_integ[ax] + err, -4095, 4095);
      s[ax] = (err >>> 1) + (err >>> 3) + diff * 7 + (m_integ[ax] >>> 6);
    end
    base = int'(thrst) + 'h2C0;
    if (inertial_cal) begin
      for (int k = 0; k < 4; k++) exp_spd[k] = 'h290;
    end else begin
      exp_spd[0] = clampi(base - s[0] - s[2], 0, 2047);
      exp_spd[1] = clampi(base + s[0] - s[2], 0, 2047);
      exp_spd[2] = clampi(base - s[1] + s[2], 0, 2047);
      exp_spd[3] = clampi(base + s[1] + s[2], 0, 2047);
    end
  endtask

  // One accepted reading; optionally a second vld busy_at cycles later.
  task automatic run_txn(input int busy_at);
    vld = 1'b1;
    tick();
    vld = 1'b0;
    model_accept();
    for (int k = 1; k <= 5; k++) begin
      if (k == busy_at) begin
        vld = 1'b1;
        exp_ovr = 1;
      end
      tick();
      vld = 1'b0;
      if (k < 5) check_val("spd_vld_early", int'(spd_vld), 0);
    end
    check_val("spd_vld", int'(spd_vld), 1);
    check_val("frnt", int'(frnt_spd), exp_spd[0]);
    check_val("bck", int'(bck_spd), exp_spd[1]);
    check_val("lft", int'(lft_spd), exp_spd[2]);
    check_val("rght", int'(rght_spd), exp_spd[3]);
    check_val("overrun", int'(overrun), exp_ovr);
    $display("txn %0d: ptch=%0d roll=%0d yaw=%0d dp=%0d dr=%0d dy=%0d thrst=%0h cal=%0b busy=%0d -> f=%0h b=%0h l=%0h r=%0h ovr=%0b",
             n_txn, ptch, roll, yaw, d_ptch, d_roll, d_yaw, thrst, inertial_cal, busy_at,
             frnt_spd, bck_spd, lft_spd, rght_spd, overrun);
    n_txn++;
    tick();
    check_val("spd_vld_pulse", int'(spd_vld), 0);
    check_val("frnt_hold", int'(frnt_spd), exp_spd[0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_angles(input int p, input int r, input int y,
                            input int dp, input int dr, input int dy, input int t);
    ptch = 16'(p); roll = 16'(r); yaw = 16'(y);
    d_ptch = 16'(dp); d_roll = 16'(dr); d_yaw = 16'(dy);
    thrst = THRST_W'(t);
  endtask

  function automatic int rand_ang();
    case ($urandom_range(0, 2))
      0: return int'($urandom_range(0, 600)) - 300;
      1: return int'($urandom_range(0, 2400)) - 1200;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    int pulses;
    model_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_val("rst_frnt", int'(frnt_spd), 0);
    check_val("rst_bck", int'(bck_spd), 0);
    check_val("rst_lft", int'(lft_spd), 0);
    check_val("rst_rght", int'(rght_spd), 0);
    check_val("rst_spd_vld", int'(spd_vld), 0);
    check_val("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // Level flight: every motor at thrust plus base speed.
    set_angles(0, 0, 0, 0, 0, 0, 'h100);
    run_txn(0);
    check_val("t1_frnt_abs", int'(frnt_spd), 'h3C0);

    // Single pitch error.
    do_reset();
    set_angles(100, 0, 0, 0, 0, 0, 'h100);
    run_txn(0);
    check_val("t2_frnt_abs", int'(frnt_spd), 'h1C8);
    check_val("t2_bck_abs", int'(bck_spd), 'h5B8);

    // Large negative pitch and yaw: front clamps high.
    do_reset();
    set_angles(-2000, 0, -2000, 0, 0, 0, 'h1FF);
    run_txn(0);
    check_val("t3_frnt_abs", int'(frnt_spd), 'h7FF);
    check_val("t3_bck_abs", int'(bck_spd), 'h4BF);
    check_val("t3_lft_abs", int'(lft_spd), 'h1B7);

    // Zero thrust, large positive pitch: front clamps low.
    do_reset();
    set_angles(2000, 0, 0, 0, 0, 0, 0);
    run_txn(0);
    check_val("t4_frnt_abs", int'(frnt_spd), 0);

    // Sustained pitch error drives the integrator into its clamp.
    do_reset();
    set_angles(511, 0, 0, 0, 0, 0, 'h100);
    for (int n = 0; n < 100; n++) run_txn(0);
    // s_ptch = 318 (P) + 0 (D) + 63 (I): 960 - 381 = 579.
    check_val("t5_frnt_sat", int'(frnt_spd), 579);
    inertial_cal = 1'b1;
    run_txn(0);
    check_val("t5_cal_rght", int'(rght_spd), 'h290);
    inertial_cal = 1'b0;
    run_txn(0);

    // Busy vld is ignored and overrun stays set.
    do_reset();
    set_angles(37, -20, 15, 0, 5, 0, 'h80);
    run_txn(2);
    set_angles(-60, 44, 0, 10, 0, -9, 'h150);
    run_txn(0);

    // Reset in the middle of a sequence.
    vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_frnt", int'(frnt_spd), 0);
    check_val("mid_rst_bck", int'(bck_spd), 0);
    check_val("mid_rst_spd_vld", int'(spd_vld), 0);
    check_val("mid_rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    model_reset();
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (spd_vld) pulses++;
    end
    check_val("mid_rst_no_pulse", pulses, 0);

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      set_angles(rand_ang(), rand_ang(), rand_ang(), rand_ang(), rand_ang(), rand_ang(),
                 int'($urandom_range(0, (1 << THRST_W) - 1)));
      inertial_cal = ($urandom_range(0, 7) == 0);
      run_txn(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
